dmem_byte_word: RTL and testbench



---
 rtl/dmem_byte_word_pkg.sv | 24 ++
 rtl/dmem_byte_lane.sv | 52 +++++
 rtl/dmem_byte_word.sv | 69 ++++++
 tb/tb_dmem_byte_word.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/dmem_byte_word_pkg.sv
// Shared constants for the CPU data memory: depth, byte-lane encodings,
// access-size encoding and a byte sign-extension helper.
package dmem_byte_word_pkg;

    // Number of 32-bit words in the data memory (power of two).
    localparam int DMEM_DEPTH_WORDS = 256;
    localparam int DMEM_ADDR_W      = $clog2(DMEM_DEPTH_WORDS);

    // Little-endian byte lanes within a word, taken from addr[1:0].
    localparam logic [1:0] LANE0 = 2'd0;  // bits [7:0]
    localparam logic [1:0] LANE1 = 2'd1;  // bits [15:8]
    localparam logic [1:0] LANE2 = 2'd2;  // bits [23:16]
    localparam logic [1:0] LANE3 = 2'd3;  // bits [31:24]

    // Access size carried on i_DMem_sByte.
    localparam logic SIZE_WORD = 1'b0;
    localparam logic SIZE_BYTE = 1'b1;

    // lb semantics: replicate bit 7 into the upper 24 bits.
    function automatic logic [31:0] sext8(input logic [7:0] b);
        return {{24{b[7]}}, b};
    endfunction

endpackage

// File: rtl/dmem_byte_lane.sv
// Byte-lane helper for the data memory: picks and sign-extends the load
// byte, and produces the lane write mask plus lane-aligned store data.
module dmem_byte_lane
    import dmem_byte_word_pkg::*;
(
    input  logic        i_s_byte,     // SIZE_BYTE or SIZE_WORD
    input  logic [1:0]  i_lane,       // addr[1:0]
    input  logic [31:0] i_rword,      // full word currently stored at the index
    input  logic [31:0] i_wdata,      // raw store data from the MEM stage
    output logic [31:0] o_rdata,      // load result (word or sign-extended byte)
    output logic [3:0]  o_wmask,      // one bit per lane to be written
    output logic [31:0] o_wdata_lane  // store data placed on its lane(s)
);

    logic [7:0] sel_byte;

    // Load path: select the addressed lane, then word pass-through or lb extension.
    always_comb begin
        sel_byte = i_rword[7:0];
        case (i_lane)
            LANE0:   sel_byte = i_rword[7:0];
            LANE1:   sel_byte = i_rword[15:8];
            LANE2:   sel_byte = i_rword[23:16];
            LANE3:   sel_byte = i_rword[31:24];
            default: sel_byte = i_rword[7:0];
        endcase

        if (i_s_byte == SIZE_BYTE) begin
            o_rdata = sext8(sel_byte);
        end else begin
            o_rdata = i_rword;
        end
    end

    // Store path: a byte store touches one lane with wdata[7:0] copied to every
    // lane so the mask alone decides placement; a word store touches all lanes.
    always_comb begin
        o_wmask      = 4'b1111;
        o_wdata_lane = i_wdata;
        if (i_s_byte == SIZE_BYTE) begin
            o_wdata_lane = {4{i_wdata[7:0]}};
            case (i_lane)
                LANE0:   o_wmask = 4'b0001;
                LANE1:   o_wmask = 4'b0010;
                LANE2:   o_wmask = 4'b0100;
                LANE3:   o_wmask = 4'b1000;
                default: o_wmask = 4'b0001;
            endcase
        end
    end

endmodule

// File: rtl/dmem_byte_word.sv
// MEM-stage data memory with word and byte access. Reads are combinational
// from the current address; writes land on the rising clock edge. The whole
// array is cleared asynchronously while rstn is low.
module dmem_byte_word
    import dmem_byte_word_pkg::*;
#(
    parameter int DEPTH_WORDS = DMEM_DEPTH_WORDS,
    parameter int ADDR_W      = $clog2(DEPTH_WORDS)
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        i_DMem_dMemWe,
    input  logic        i_DMem_sByte,
    input  logic [31:0] i_DMem_addr,
    input  logic [31:0] i_DMem_wData,
    output logic [31:0] o_DMem_rData
);

    logic [31:0]       mem_q [DEPTH_WORDS];

    logic [ADDR_W-1:0] word_idx;
    logic [1:0]        lane;
    logic [31:0]       rword;
    logic [3:0]        wmask;
    logic [31:0]       wdata_lane;
    logic [31:0]       wmask_bits;
    logic [31:0]       wr_word_d;
    logic              wr_en_d;

    // Upper address bits wrap away by design; they are intentionally unused.
    logic              unused_addr_hi;
    assign unused_addr_hi = ^i_DMem_addr[31:ADDR_W+2];

    assign word_idx = i_DMem_addr[ADDR_W+1:2];
    assign lane     = i_DMem_addr[1:0];
    assign rword    = mem_q[word_idx];

    dmem_byte_lane u_lane (
        .i_s_byte     (i_DMem_sByte),
        .i_lane       (lane),
        .i_rword      (rword),
        .i_wdata      (i_DMem_wData),
        .o_rdata      (o_DMem_rData),
        .o_wmask      (wmask),
        .o_wdata_lane (wdata_lane)
    );

    // Merge the new lane(s) into the stored word; untouched lanes keep old data.
    always_comb begin
        wmask_bits = '0;
        for (int i = 0; i < 4; i++) begin
            wmask_bits[8*i +: 8] = {8{wmask[i]}};
        end
        wr_word_d = (rword & ~wmask_bits) | (wdata_lane & wmask_bits);
        wr_en_d   = i_DMem_dMemWe;
    end

    // Storage: async clear on reset, single-word write on the rising edge.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < DEPTH_WORDS; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_en_d) begin
            mem_q[word_idx] <= wr_word_d;
        end
    end

endmodule

// File: tb/tb_dmem_byte_word.sv
// Bench for dmem_byte_word: directed vector table, async-reset sequence and
// a randomized phase against a behavioural memory model.
module tb_dmem_byte_word;

    logic        clk;
    logic        rstn;
    logic        i_DMem_dMemWe;
    logic        i_DMem_sByte;
    logic [31:0] i_DMem_addr;
    logic [31:0] i_DMem_wData;
    logic [31:0] o_DMem_rData;

    logic [31:0] exp_q[$];
    int          n_checks;
    int          n_fail;

    logic [31:0] model_mem [256];

    typedef struct {
        logic        we;
        logic        sbyte;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_pre;   // output before the edge
        logic [31:0] exp_post;  // output after the edge
    } vec_t;

    vec_t vecs [21];

    dmem_byte_word dut (
        .clk           (clk),
        .rstn          (rstn),
        .i_DMem_dMemWe (i_DMem_dMemWe),
        .i_DMem_sByte  (i_DMem_sByte),
        .i_DMem_addr   (i_DMem_addr),
        .i_DMem_wData  (i_DMem_wData),
        .o_DMem_rData  (o_DMem_rData)
    );

    // Clock: 10 time-unit period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pop one expected value and compare it with the live output.
    task automatic check(input string name);
        logic [31:0] exp;
        n_checks++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL %s: scoreboard empty, got %h", name, o_DMem_rData);
        end else begin
            exp = exp_q.pop_front();
            if (o_DMem_rData !== exp) begin
                n_fail++;
                $display("FAIL %s: got %h expected %h (addr %h sbyte %0b)",
                         name, o_DMem_rData, exp, i_DMem_addr, i_DMem_sByte);
            end
        end
    endtask

    // Drive one access between edges, check output before and after the edge.
    task automatic apply(input vec_t v, input string name);
        @(negedge clk);
        i_DMem_dMemWe = v.we;
        i_DMem_sByte  = v.sbyte;
        i_DMem_addr   = v.addr;
        i_DMem_wData  = v.wdata;
        exp_q.push_back(v.exp_pre);
        #1;
        check({name, "_pre"});
        @(posedge clk);
        exp_q.push_back(v.exp_post);
        #1;
        check({name, "_post"});
        i_DMem_dMemWe = 1'b0;
    endtask

    function automatic logic [31:0] model_read(input logic sb, input logic [31:0] a);
        logic [31:0] w;
        logic [7:0]  b;
        w = model_mem[a[9:2]];
        b = w[8*a[1:0] +: 8];
        return sb ? {{24{b[7]}}, b} : w;
    endfunction

    initial begin
        n_checks      = 0;
        n_fail        = 0;
        rstn          = 1'b0;
        i_DMem_dMemWe = 1'b0;
        i_DMem_sByte  = 1'b0;
        i_DMem_addr   = '0;
        i_DMem_wData  = '0;

        //          we    sb    addr          wdata         pre           post
        vecs[0]  = '{1'b0, 1'b0, 32'h0000_0000, 32'h0,        32'h0,        32'h0};
        vecs[1]  = '{1'b0, 1'b0, 32'h0000_0004, 32'h0,        32'h0,        32'h0};
        vecs[2]  = '{1'b0, 1'b0, 32'h0000_03FC, 32'h0,        32'h0,        32'h0};
        vecs[3]  = '{1'b1, 1'b0, 32'h0000_0010, 32'hDEADBEEF, 32'h0,        32'hDEADBEEF};
        vecs[4]  = '{1'b0, 1'b0, 32'h0000_0010, 32'h0,        32'hDEADBEEF, 32'hDEADBEEF};
        vecs[5]  = '{1'b0, 1'b0, 32'h0000_0013, 32'h0,        32'hDEADBEEF, 32'hDEADBEEF};
        vecs[6]  = '{1'b1, 1'b0, 32'h0000_0020, 32'h11223344, 32'h0,        32'h11223344};
        vecs[7]  = '{1'b1, 1'b1, 32'h0000_0021, 32'hFFFFFFAA, 32'h00000033, 32'hFFFFFFAA};
        vecs[8]  = '{1'b0, 1'b0, 32'h0000_0020, 32'h0,        32'h1122AA44, 32'h1122AA44};
        vecs[9]  = '{1'b1, 1'b1, 32'h0000_0023, 32'h00000055, 32'h00000011, 32'h00000055};
        vecs[10] = '{1'b0, 1'b0, 32'h0000_0020, 32'h0,        32'h5522AA44, 32'h5522AA44};
        vecs[11] = '{1'b0, 1'b1, 32'h0000_0021, 32'h0,        32'hFFFFFFAA, 32'hFFFFFFAA};
        vecs[12] = '{1'b0, 1'b1, 32'h0000_0023, 32'h0,        32'h00000055, 32'h00000055};
        vecs[13] = '{1'b0, 1'b1, 32'h0000_0020, 32'h0,        32'h00000044, 32'h00000044};
        vecs[14] = '{1'b0, 1'b1, 32'h0000_0022, 32'h0,        32'h00000022, 32'h00000022};
        vecs[15] = '{1'b0, 1'b0, 32'h0000_0030, 32'h12345678, 32'h0,        32'h0};
        vecs[16] = '{1'b1, 1'b0, 32'h0000_0030, 32'h12345678, 32'h0,        32'h12345678};
        vecs[17] = '{1'b1, 1'b0, 32'h0000_0400, 32'hCAFEF00D, 32'h0,        32'hCAFEF00D};
        vecs[18] = '{1'b0, 1'b0, 32'h0000_0000, 32'h0,        32'hCAFEF00D, 32'hCAFEF00D};
        vecs[19] = '{1'b1, 1'b1, 32'h0000_0032, 32'h00000080, 32'h00000034, 32'hFFFFFF80};
        vecs[20] = '{1'b0, 1'b0, 32'h0000_0030, 32'h0,        32'h12805678, 32'h12805678};

        // Reset: array must read zero during reset.
        repeat (2) @(posedge clk);
        #1;
        exp_q.push_back(32'h0);
        check("reset_hold");
        @(negedge clk);
        rstn = 1'b1;

        for (int i = 0; i < 21; i++) begin
            apply(vecs[i], $sformatf("vec%0d", i));
        end

        // Async reset between edges, then a write attempted while held in reset.
        @(negedge clk);
        i_DMem_sByte = 1'b0;
        i_DMem_addr  = 32'h0;
        #1;
        exp_q.push_back(32'hCAFEF00D);
        check("pre_async_rst");
        #1;
        rstn = 1'b0;
        #1;
        exp_q.push_back(32'h0);
        check("async_rst_clear");
        i_DMem_dMemWe = 1'b1;
        i_DMem_wData  = 32'hFFFF_FFFF;
        @(posedge clk);
        #1;
        exp_q.push_back(32'h0);
        check("write_in_rst");
        @(negedge clk);
        i_DMem_dMemWe = 1'b0;
        rstn          = 1'b1;
        #1;
        exp_q.push_back(32'h0);
        check("after_rst_idx0");
        i_DMem_addr = 32'h10;
        #1;
        exp_q.push_back(32'h0);
        check("after_rst_idx4");

        // Random phase against the behavioural model (array is all zero here).
        for (int i = 0; i < 256; i++) model_mem[i] = '0;
        for (int i = 0; i < 300; i++) begin
            vec_t v;
            v.we    = ($urandom_range(0, 1) == 1);
            v.sbyte = ($urandom_range(0, 1) == 1);
            // Mostly small addresses to revisit words; sometimes full range for wrap.
            v.addr  = ($urandom_range(0, 3) == 0) ? $urandom() : 32'($urandom_range(0, 63));
            v.wdata = $urandom();
            v.exp_pre = model_read(v.sbyte, v.addr);
            if (v.we) begin
                if (v.sbyte) model_mem[v.addr[9:2]][8*v.addr[1:0] +: 8] = v.wdata[7:0];
                else         model_mem[v.addr[9:2]] = v.wdata;
            end
            v.exp_post = model_read(v.sbyte, v.addr);
            apply(v, $sformatf("rand%0d", i));
        end

        if (exp_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL scoreboard_drain: %0d left, expected 0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
